// File: rtl/hms_readback.sv
// Snapshot readback for the hms clock: a single field or a framed 6-byte burst over a valid/ready byte stream.
// Define HMS_READBACK_BCD_EN to emit time fields as packed BCD instead of zero-extended binary.
module hms_readback #(
   parameter logic [7:0] HDR = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] hrs,
   input  logic [5:0] min,
   input  logic [5:0] sec,
   input  logic       am_pm_bar,
   input  logic       rd_req,
   input  logic [2:0] rd_addr,
   output logic [7:0] dout,
   output logic       dout_valid,
   input  logic       dout_ready,
   output logic       busy,
   output logic       err
);

   typedef enum logic [2:0] {
      S_IDLE, S_SINGLE, S_HDR, S_B_HRS, S_B_MIN, S_B_SEC, S_B_FLG, S_B_CHK
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] snap_hrs_q;
   logic [5:0] snap_min_q, snap_sec_q;
   logic       snap_ap_q;
   logic [2:0] addr_q;
   logic [7:0] dout_q, dout_d;
   logic       valid_q, valid_d;
   logic       busy_q, busy_d;
   logic       err_q, err_d;
   logic       single_ok_s, burst_ok_s, accept_s;
   logic [7:0] hrs_b_s, min_b_s, sec_b_s, flg_b_s, chk_b_s, byte_s;

   function automatic logic [7:0] enc_field(input logic [5:0] v);
`ifdef HMS_READBACK_BCD_EN
      logic [3:0] tens_v;
      logic [3:0] units_v;
      tens_v  = 4'(v / 6'd10);
      units_v = 4'(v % 6'd10);
      return {tens_v, units_v};
`else
      return {2'b00, v};
`endif
   endfunction

   assign single_ok_s = (rd_addr >= 3'd1) && (rd_addr <= 3'd4);
   assign burst_ok_s  = (rd_addr == 3'd7);
   assign accept_s    = (state_q == S_IDLE) && rd_req && (single_ok_s || burst_ok_s);

   assign hrs_b_s = enc_field({2'b00, snap_hrs_q});
   assign min_b_s = enc_field(snap_min_q);
   assign sec_b_s = enc_field(snap_sec_q);
   assign flg_b_s = {7'b0000000, snap_ap_q};
   assign chk_b_s = HDR ^ hrs_b_s ^ min_b_s ^ sec_b_s ^ flg_b_s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         snap_hrs_q <= 4'd0;
         snap_min_q <= 6'd0;
         snap_sec_q <= 6'd0;
         snap_ap_q  <= 1'b0;
         addr_q     <= 3'd0;
         dout_q     <= 8'h00;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         if (accept_s) begin
            snap_hrs_q <= hrs;
            snap_min_q <= min;
            snap_sec_q <= sec;
            snap_ap_q  <= am_pm_bar;
            addr_q     <= rd_addr;
         end
      end
   end

   // A state advances only when its byte has actually been transferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (rd_req && burst_ok_s) begin
               state_d = S_HDR;
            end else if (rd_req && single_ok_s) begin
               state_d = S_SINGLE;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            if (valid_q && dout_ready) begin
               case (state_q)
                  S_HDR:   state_d = S_B_HRS;
                  S_B_HRS: state_d = S_B_MIN;
                  S_B_MIN: state_d = S_B_SEC;
                  S_B_SEC: state_d = S_B_FLG;
                  S_B_FLG: state_d = S_B_CHK;
                  default: state_d = S_IDLE;
               endcase
            end else begin
               state_d = state_q;
            end
         end
      endcase
   end

   // The byte belonging to the next state is registered so it appears on the same edge as the move.
   always_comb begin
      byte_s = 8'h00;
      case (state_d)
         S_SINGLE: begin
            case (addr_q)
               3'd1:    byte_s = sec_b_s;
               3'd2:    byte_s = min_b_s;
               3'd3:    byte_s = hrs_b_s;
               default: byte_s = flg_b_s;
            endcase
         end
         S_HDR:   byte_s = HDR;
         S_B_HRS: byte_s = hrs_b_s;
         S_B_MIN: byte_s = min_b_s;
         S_B_SEC: byte_s = sec_b_s;
         S_B_FLG: byte_s = flg_b_s;
         S_B_CHK: byte_s = chk_b_s;
         default: byte_s = 8'h00;
      endcase
      valid_d = (state_q != S_IDLE) && (state_d != S_IDLE);
      if (valid_d) begin
         dout_d = byte_s;
      end else begin
         dout_d = dout_q;
      end
      busy_d = (state_d != S_IDLE);
      err_d  = rd_req && !accept_s;
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign busy       = busy_q;
   assign err        = err_q;

endmodule

// File: tb/tb_hms_readback.sv
// Randomized and directed bench for hms_readback, checked against a frame-queue model.
module tb_hms_readback;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] hrs;
   logic [5:0] min, sec;
   logic       am_pm_bar, rd_req, dout_ready;
   logic [2:0] rd_addr;
   logic [7:0] dout;
   logic       dout_valid, busy, err;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [7:0] q[$];
   logic [7:0] cap[$];
   logic       exp_valid, exp_busy, exp_err;
   logic [7:0] exp_dout;

   always #5 clk = ~clk;

   hms_readback dut (
      .clk(clk), .rst(rst), .hrs(hrs), .min(min), .sec(sec), .am_pm_bar(am_pm_bar),
      .rd_req(rd_req), .rd_addr(rd_addr), .dout(dout), .dout_valid(dout_valid),
      .dout_ready(dout_ready), .busy(busy), .err(err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %0h, want %0h at %0t", name, act, req, $time);
   endtask

   function automatic logic [7:0] enc(input int v);
`ifdef HMS_READBACK_BCD_EN
      return 8'(((v / 10) * 16) + (v % 10));
`else
      return 8'(v);
`endif
   endfunction

   // Frame-level reference: a queue of bytes still owed, with a one-cycle load delay.
   task automatic model_step();
      logic bb, ok;
      logic [7:0] x;
      bb = (q.size() != 0);
      ok = (rd_addr >= 3'd1 && rd_addr <= 3'd4) || rd_addr == 3'd7;
      exp_err = rd_req && (bb || !ok);
      if (bb) begin
         if (!exp_valid) begin
            exp_valid = 1'b1;
            exp_dout = q[0];
         end else if (dout_ready) begin
            void'(q.pop_front());
            if (q.size() == 0) exp_valid = 1'b0;
            else exp_dout = q[0];
         end
      end else if (rd_req && ok) begin
         case (rd_addr)
            3'd1: q.push_back(enc(int'(sec)));
            3'd2: q.push_back(enc(int'(min)));
            3'd3: q.push_back(enc(int'(hrs)));
            3'd4: q.push_back({7'd0, am_pm_bar});
            default: begin
               q.push_back(8'hA5);
               q.push_back(enc(int'(hrs)));
               q.push_back(enc(int'(min)));
               q.push_back(enc(int'(sec)));
               q.push_back({7'd0, am_pm_bar});
               x = 8'h00;
               foreach (q[i]) x ^= q[i];
               q.push_back(x);
            end
         endcase
      end
      exp_busy = (q.size() != 0);
   endtask

   task automatic model_reset();
      q.delete();
      exp_valid = 1'b0;
      exp_busy = 1'b0;
      exp_err = 1'b0;
      exp_dout = 8'h00;
   endtask

   task automatic compare();
      chk("dout_valid", dout_valid, exp_valid);
      chk("busy", busy, exp_busy);
      chk("err", err, exp_err);
      if (exp_valid) chk("dout", dout, exp_dout);
   endtask

   task automatic cycle(input logic rq, input logic [2:0] ad, input logic rdy);
      rd_req = rq;
      rd_addr = ad;
      dout_ready = rdy;
      if (dout_valid && dout_ready) cap.push_back(dout);
      @(posedge clk);
      if (rst) model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic set_time(input int h, input int m, input int s, input logic ap);
      hrs = 4'(h);
      min = 6'(m);
      sec = 6'(s);
      am_pm_bar = ap;
   endtask

   logic [7:0] lit[6];

   initial begin
      rst = 1'b0;
      rd_req = 1'b0;
      rd_addr = 3'd0;
      dout_ready = 1'b0;
      set_time(1, 0, 0, 1'b0);
      model_reset();
      #2;
      repeat (3) cycle(1'b0, 3'd0, 1'b1);
      chk("reset_dout", dout, 8'h00);
      rst = 1'b1;

      // Single read of seconds.
      set_time(11, 59, 55, 1'b1);
      cap.delete();
      cycle(1'b1, 3'd1, 1'b1);
      repeat (4) cycle(1'b0, 3'd0, 1'b1);
      chk("single_count", cap.size(), 1);
`ifdef HMS_READBACK_BCD_EN
      chk("single_byte", cap[0], 8'h55);
      lit = '{8'hA5, 8'h11, 8'h59, 8'h55, 8'h01, 8'hB9};
`else
      chk("single_byte", cap[0], 8'h37);
      lit = '{8'hA5, 8'h0B, 8'h3B, 8'h37, 8'h01, 8'hA3};
`endif

      // Full-rate burst.
      cap.delete();
      cycle(1'b1, 3'd7, 1'b1);
      repeat (8) cycle(1'b0, 3'd0, 1'b1);
      chk("burst_count", cap.size(), 6);
      for (int i = 0; i < 6; i++) chk("burst_byte", cap[i], lit[i]);

      // Backpressure while the live time rolls over.
      set_time(11, 59, 59, 1'b0);
      cap.delete();
      cycle(1'b1, 3'd7, 1'b0);
      for (int k = 0; k < 20; k++) begin
         set_time(12, 0, k, 1'b1);
         cycle(1'b0, 3'd0, 1'b0);
      end
      chk("bp_hold", dout, 8'hA5);
      repeat (8) cycle(1'b0, 3'd0, 1'b1);
      chk("bp_count", cap.size(), 6);
`ifdef HMS_READBACK_BCD_EN
      chk("bp_hrs", cap[1], 8'h11);
      chk("bp_min", cap[2], 8'h59);
      chk("bp_sec", cap[3], 8'h59);
      chk("bp_chk", cap[5], 8'hB4);
`else
      chk("bp_hrs", cap[1], 8'h0B);
      chk("bp_min", cap[2], 8'h3B);
      chk("bp_sec", cap[3], 8'h3B);
      chk("bp_chk", cap[5], 8'hAE);
`endif

      // Invalid address in idle.
      cap.delete();
      cycle(1'b1, 3'd5, 1'b1);
      chk("err_pulse", err, 1'b1);
      cycle(1'b0, 3'd0, 1'b1);
      chk("err_clear", err, 1'b0);
      chk("err_novalid", cap.size(), 0);

      // Request during a burst.
      set_time(11, 59, 55, 1'b1);
      cycle(1'b1, 3'd7, 1'b1);
      cycle(1'b1, 3'd3, 1'b1);
      chk("busy_err", err, 1'b1);
      repeat (8) cycle(1'b0, 3'd0, 1'b1);
      chk("busy_err_count", cap.size(), 6);
      chk("busy_err_chk", cap[5], lit[5]);

      // Reset in the middle of a burst.
      set_time(3, 7, 10, 1'b0);
      cycle(1'b1, 3'd7, 1'b1);
      repeat (3) cycle(1'b0, 3'd0, 1'b1);
      rst = 1'b0;
      #1;
      chk("rst_valid", dout_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      model_reset();
      @(negedge clk);
      cycle(1'b0, 3'd0, 1'b1);
      rst = 1'b1;
      cap.delete();
      cycle(1'b1, 3'd7, 1'b1);
      repeat (8) cycle(1'b0, 3'd0, 1'b1);
      chk("post_rst_hdr", cap[0], 8'hA5);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 7) == 0)
            set_time($urandom_range(1, 12), $urandom_range(0, 59), $urandom_range(0, 59),
                     1'($urandom_range(0, 1)));
         cycle(1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 3) != 0));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
